shim_avst_fifo: RTL



---
 rtl/dc_bsp_pkg.sv | 7 +
 rtl/shim_avst_if.sv | 15 +
 rtl/shim_avst_fifo.sv | 77 +++++++
 3 files changed

// File: rtl/dc_bsp_pkg.sv
// Board-support constants shared by the AVST shim blocks.
package dc_bsp_pkg;

    localparam int SHIM_AVST_DATA_WIDTH = 8;
    localparam int SHIM_AVST_FIFO_DEPTH = 16;

endpackage

// File: rtl/shim_avst_if.sv
// Minimal Avalon-ST style handshake bundle: valid/data forward, ready backward.
interface shim_avst_if
    import dc_bsp_pkg::*;
#(
    parameter int DATA_WIDTH = SHIM_AVST_DATA_WIDTH
);

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport sink   (input valid, input data, output ready);
    modport source (output valid, output data, input ready);

endinterface

// File: rtl/shim_avst_fifo.sv
// Synchronous AVST beat FIFO with registered occupancy and almost-full flag.
// Output side is driven purely from storage and registered pointers.
module shim_avst_fifo
    import dc_bsp_pkg::*;
#(
    parameter int DATA_WIDTH = SHIM_AVST_DATA_WIDTH,
    parameter int DEPTH      = SHIM_AVST_FIFO_DEPTH,
    parameter int AF_THRESH  = DEPTH - 4
) (
    input  logic                   clk,
    input  logic                   reset,
    shim_avst_if.sink              in_st,
    shim_avst_if.source            out_st,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("shim_avst_fifo: DEPTH must be a power of two and at least 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
        $error("shim_avst_fifo: AF_THRESH must lie in 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_next;
    logic                  af_q;
    logic                  push;
    logic                  pop;

    // Ready is a function of registered occupancy only, so a downstream pop
    // frees the slot for the upstream side one cycle later.
    assign in_st.ready  = (count_q != CNT_W'(DEPTH)) && !reset;
    assign out_st.valid = (count_q != '0);
    assign out_st.data  = mem[rd_ptr];

    assign push = in_st.valid && in_st.ready;
    assign pop  = out_st.valid && out_st.ready;

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_next;
            af_q    <= (count_next >= CNT_W'(AF_THRESH));
        end
    end

    // Storage carries no reset; emptiness is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_st.data;
    end

    assign fill_level  = count_q;
    assign almost_full = af_q;

endmodule
